id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage RISC-V core; directly consumes the register-file read ports (RD1data/RD2data) plus decoded control and immediate from ID.
- Contains load-use hazard detection. Inserts one bubble per load-use hazard and back-pressures PC and IF/ID.
- Supports branch flush, downstream hold and a saturating hazard-stall performance counter.

---
 rtl/core_pkg.sv | 25 ++
 rtl/id_ex_stage_if.sv | 50 +++++
 rtl/hazard_detect.sv | 24 ++
 rtl/id_ex_stage.sv | 102 ++++++++++
 tb/tb_id_ex_stage.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants: control-word layout, ALUOp codes, register addressing
package core_pkg;

    localparam int CTRL_W     = 7;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    // Control word layout: {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0]}
    localparam int CTRL_REGWRITE  = 6;
    localparam int CTRL_MEMTOREG  = 5;
    localparam int CTRL_MEMREAD   = 4;
    localparam int CTRL_MEMWRITE  = 3;
    localparam int CTRL_ALUSRC    = 2;
    localparam int CTRL_ALUOP     = 0;
    localparam int CTRL_ALUOP_MSB = 1;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } aluop_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID-side inputs and EX-side outputs of the ID/EX pipeline register
interface id_ex_stage_if
    import core_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic                  id_valid_i;
    logic [REG_ADDR_W-1:0] id_rs1_i;
    logic [REG_ADDR_W-1:0] id_rs2_i;
    logic [REG_ADDR_W-1:0] id_rd_i;
    logic                  id_use_rs1_i;
    logic                  id_use_rs2_i;
    logic [DATA_W-1:0]     id_rs1_data_i;
    logic [DATA_W-1:0]     id_rs2_data_i;
    logic [DATA_W-1:0]     id_imm_i;
    logic [9:0]            id_funct_i;
    logic [CTRL_W-1:0]     id_ctrl_i;
    logic                  flush_i;
    logic                  hold_i;

    logic                  ex_valid_o;
    logic [REG_ADDR_W-1:0] ex_rs1_o;
    logic [REG_ADDR_W-1:0] ex_rs2_o;
    logic [REG_ADDR_W-1:0] ex_rd_o;
    logic [DATA_W-1:0]     ex_rs1_data_o;
    logic [DATA_W-1:0]     ex_rs2_data_o;
    logic [DATA_W-1:0]     ex_imm_o;
    logic [9:0]            ex_funct_o;
    logic [CTRL_W-1:0]     ex_ctrl_o;
    logic                  hazard_o;
    logic                  stall_o;
    logic [CNT_W-1:0]      stall_cnt_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_use_rs1_i, id_use_rs2_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_funct_i, id_ctrl_i,
               flush_i, hold_i,
        input  ex_valid_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_rs1_data_o, ex_rs2_data_o,
               ex_imm_o, ex_funct_o, ex_ctrl_o, hazard_o, stall_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_use_rs1_i, id_use_rs2_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_funct_i, id_ctrl_i,
               flush_i, hold_i,
        output ex_valid_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_rs1_data_o, ex_rs2_data_o,
               ex_imm_o, ex_funct_o, ex_ctrl_o, hazard_o, stall_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard check of one ID instruction against one EX load
module hazard_detect
    import core_pkg::*;
(
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  hazard
);
    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_match = id_use_rs2 && (id_rs2 == ex_rd);

    // A load into x0 never produces a value, so nothing can depend on it.
    assign hazard = id_valid && ex_valid && ex_mem_read && (ex_rd != REG_X0)
                    && (rs1_match || rs2_match);
endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion and stall counter
module id_ex_stage
    import core_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    id_ex_stage_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                  ex_valid_q;
    logic [REG_ADDR_W-1:0] ex_rs1_q;
    logic [REG_ADDR_W-1:0] ex_rs2_q;
    logic [REG_ADDR_W-1:0] ex_rd_q;
    logic [DATA_W-1:0]     ex_rs1_data_q;
    logic [DATA_W-1:0]     ex_rs2_data_q;
    logic [DATA_W-1:0]     ex_imm_q;
    logic [9:0]            ex_funct_q;
    logic [CTRL_W-1:0]     ex_ctrl_q;
    logic [CNT_W-1:0]      stall_cnt_q;

    logic hazard;
    logic load_bubble;
    logic capture;
    logic count_hazard;

    hazard_detect u_hazard_detect (
        .id_valid    (bus.id_valid_i),
        .id_rs1      (bus.id_rs1_i),
        .id_rs2      (bus.id_rs2_i),
        .id_use_rs1  (bus.id_use_rs1_i),
        .id_use_rs2  (bus.id_use_rs2_i),
        .ex_valid    (ex_valid_q),
        .ex_mem_read (ex_ctrl_q[CTRL_MEMREAD]),
        .ex_rd       (ex_rd_q),
        .hazard      (hazard)
    );

    // Flush beats hold beats hazard; only a hazard that actually inserts a bubble is counted.
    assign load_bubble  = bus.flush_i || (!bus.hold_i && hazard);
    assign capture      = !bus.flush_i && !bus.hold_i && !hazard;
    assign count_hazard = !bus.flush_i && !bus.hold_i && hazard;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_valid_q    <= 1'b0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_funct_q    <= '0;
            ex_ctrl_q     <= '0;
        end else if (load_bubble) begin
            ex_valid_q    <= 1'b0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_funct_q    <= '0;
            ex_ctrl_q     <= '0;
        end else if (capture) begin
            ex_valid_q    <= bus.id_valid_i;
            ex_rs1_q      <= bus.id_rs1_i;
            ex_rs2_q      <= bus.id_rs2_i;
            ex_rd_q       <= bus.id_rd_i;
            ex_rs1_data_q <= bus.id_rs1_data_i;
            ex_rs2_data_q <= bus.id_rs2_data_i;
            ex_imm_q      <= bus.id_imm_i;
            ex_funct_q    <= bus.id_funct_i;
            // An empty ID slot must never carry side-effecting control into EX.
            ex_ctrl_q     <= bus.id_valid_i ? bus.id_ctrl_i : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else if (count_hazard && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.ex_valid_o    = ex_valid_q;
    assign bus.ex_rs1_o      = ex_rs1_q;
    assign bus.ex_rs2_o      = ex_rs2_q;
    assign bus.ex_rd_o       = ex_rd_q;
    assign bus.ex_rs1_data_o = ex_rs1_data_q;
    assign bus.ex_rs2_data_o = ex_rs2_data_q;
    assign bus.ex_imm_o      = ex_imm_q;
    assign bus.ex_funct_o    = ex_funct_q;
    assign bus.ex_ctrl_o     = ex_ctrl_q;
    assign bus.hazard_o      = hazard;
    assign bus.stall_o       = hazard || bus.hold_i;
    assign bus.stall_cnt_o   = stall_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage against a cycle-level reference model
module tb_id_ex_stage;
    import core_pkg::*;

    localparam logic [6:0] C_LW  = 7'b1110100;
    localparam logic [6:0] C_ADD = 7'b1000010;
    localparam logic [6:0] C_LUI = 7'b1000111;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    id_ex_stage_if #(.DATA_W(32), .CNT_W(16)) bus ();
    id_ex_stage_if #(.DATA_W(32), .CNT_W(2))  sat ();

    id_ex_stage #(.DATA_W(32), .CNT_W(16)) u_dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
    id_ex_stage #(.DATA_W(32), .CNT_W(2))  u_sat (.clk_i(clk_i), .rst_i(rst_i), .bus(sat));

    assign sat.id_valid_i    = bus.id_valid_i;
    assign sat.id_rs1_i      = bus.id_rs1_i;
    assign sat.id_rs2_i      = bus.id_rs2_i;
    assign sat.id_rd_i       = bus.id_rd_i;
    assign sat.id_use_rs1_i  = bus.id_use_rs1_i;
    assign sat.id_use_rs2_i  = bus.id_use_rs2_i;
    assign sat.id_rs1_data_i = bus.id_rs1_data_i;
    assign sat.id_rs2_data_i = bus.id_rs2_data_i;
    assign sat.id_imm_i      = bus.id_imm_i;
    assign sat.id_funct_i    = bus.id_funct_i;
    assign sat.id_ctrl_i     = bus.id_ctrl_i;
    assign sat.flush_i       = bus.flush_i;
    assign sat.hold_i        = bus.hold_i;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [9:0]  funct;
        logic [6:0]  ctrl;
    } slot_t;

    slot_t       m = '0;
    int unsigned m_cnt = 0;
    int unsigned m_cnt_sat = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The later instruction stalls iff EX holds a real load to a nonzero register it actually reads.
    function automatic logic model_hazard();
        logic reads_it;
        reads_it = (bus.id_use_rs1_i && bus.id_rs1_i == m.rd) || (bus.id_use_rs2_i && bus.id_rs2_i == m.rd);
        return bus.id_valid_i && m.valid && m.ctrl[4] && (m.rd != 5'd0) && reads_it;
    endfunction

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m = '0; m_cnt = 0; m_cnt_sat = 0;
        end else if (bus.flush_i) begin
            m = '0;
        end else if (bus.hold_i) begin
            m = m;
        end else if (model_hazard()) begin
            m = '0;
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_sat < 3) m_cnt_sat++;
        end else begin
            m.valid = bus.id_valid_i;
            m.rs1 = bus.id_rs1_i; m.rs2 = bus.id_rs2_i; m.rd = bus.id_rd_i;
            m.d1 = bus.id_rs1_data_i; m.d2 = bus.id_rs2_data_i; m.imm = bus.id_imm_i;
            m.funct = bus.id_funct_i;
            m.ctrl = bus.id_valid_i ? bus.id_ctrl_i : 7'd0;
        end
    end

    always @(negedge clk_i) begin
        chk("ex_valid", 64'(bus.ex_valid_o), 64'(m.valid));
        chk("ex_rs1", 64'(bus.ex_rs1_o), 64'(m.rs1));
        chk("ex_rs2", 64'(bus.ex_rs2_o), 64'(m.rs2));
        chk("ex_rd", 64'(bus.ex_rd_o), 64'(m.rd));
        chk("ex_rs1_data", 64'(bus.ex_rs1_data_o), 64'(m.d1));
        chk("ex_rs2_data", 64'(bus.ex_rs2_data_o), 64'(m.d2));
        chk("ex_imm", 64'(bus.ex_imm_o), 64'(m.imm));
        chk("ex_funct", 64'(bus.ex_funct_o), 64'(m.funct));
        chk("ex_ctrl", 64'(bus.ex_ctrl_o), 64'(m.ctrl));
        chk("hazard", 64'(bus.hazard_o), 64'(rst_i && model_hazard()));
        chk("stall", 64'(bus.stall_o), 64'((rst_i && model_hazard()) || bus.hold_i));
        chk("stall_cnt", 64'(bus.stall_cnt_o), 64'(m_cnt));
        chk("sat_cnt", 64'(sat.stall_cnt_o), 64'(m_cnt_sat));
        chk("sat_valid", 64'(sat.ex_valid_o), 64'(m.valid));
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic u1, input logic u2, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [9:0] funct, input logic [6:0] ctrl);
        bus.id_valid_i = v; bus.id_rs1_i = rs1; bus.id_rs2_i = rs2; bus.id_rd_i = rd;
        bus.id_use_rs1_i = u1; bus.id_use_rs2_i = u2;
        bus.id_rs1_data_i = d1; bus.id_rs2_data_i = d2; bus.id_imm_i = imm;
        bus.id_funct_i = funct; bus.id_ctrl_i = ctrl;
    endtask

    task automatic lw_x7();
        set_id(1'b1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b0, 32'h100, 32'h0, 32'h8, 10'h002, C_LW);
    endtask

    task automatic add_x8_x7_x1();
        set_id(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b1, 32'hAAAA, 32'hBBBB, 32'h0, 10'h000, C_ADD);
    endtask

    initial begin
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 10'h0, 7'h0);
        bus.flush_i = 1'b0;
        bus.hold_i  = 1'b0;
        tick(); tick();
        chk("reset_valid", 64'(bus.ex_valid_o), 64'd0);
        chk("reset_cnt", 64'(bus.stall_cnt_o), 64'd0);
        rst_i = 1'b1;

        // plain pass-through
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 32'h1234, 32'h55, 32'h0, 10'h000, C_ADD);
        tick();
        chk("pt_rd", 64'(bus.ex_rd_o), 64'd5);
        chk("pt_rs1_data", 64'(bus.ex_rs1_data_o), 64'h1234);
        chk("pt_valid", 64'(bus.ex_valid_o), 64'd1);
        chk("pt_hazard", 64'(bus.hazard_o), 64'd0);

        // load-use: one bubble, then the dependent add enters EX
        lw_x7(); tick();
        add_x8_x7_x1(); #1;
        chk("lu_hazard", 64'(bus.hazard_o), 64'd1);
        chk("lu_stall", 64'(bus.stall_o), 64'd1);
        tick();
        chk("lu_bubble_valid", 64'(bus.ex_valid_o), 64'd0);
        chk("lu_bubble_ctrl", 64'(bus.ex_ctrl_o), 64'd0);
        chk("lu_cnt", 64'(bus.stall_cnt_o), 64'd1);
        chk("lu_hazard_drop", 64'(bus.hazard_o), 64'd0);
        tick();
        chk("lu_captured_rd", 64'(bus.ex_rd_o), 64'd8);
        chk("lu_captured_valid", 64'(bus.ex_valid_o), 64'd1);

        // load to x0, then a reader of x0
        set_id(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 32'h100, 32'h0, 32'h4, 10'h002, C_LW); tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 10'h000, C_ADD); #1;
        chk("x0_hazard", 64'(bus.hazard_o), 64'd0);
        tick();

        // load x7, then lui x7 which reads no register
        lw_x7(); tick();
        set_id(1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 32'h0, 32'h0, 32'h12345000, 10'h000, C_LUI); #1;
        chk("lui_hazard", 64'(bus.hazard_o), 64'd0);
        tick();
        chk("lui_imm", 64'(bus.ex_imm_o), 64'h12345000);

        // flush with hazard: bubble, counter unchanged
        lw_x7(); tick();
        add_x8_x7_x1(); bus.flush_i = 1'b1; #1;
        chk("fl_hazard", 64'(bus.hazard_o), 64'd1);
        tick();
        bus.flush_i = 1'b0;
        chk("fl_valid", 64'(bus.ex_valid_o), 64'd0);
        chk("fl_cnt", 64'(bus.stall_cnt_o), 64'd1);
        tick();
        chk("fl_after_rd", 64'(bus.ex_rd_o), 64'd8);

        // hold with hazard for 3 cycles: EX frozen, counter frozen
        lw_x7(); tick();
        add_x8_x7_x1(); bus.hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_rd", 64'(bus.ex_rd_o), 64'd7);
            chk("hold_valid", 64'(bus.ex_valid_o), 64'd1);
            chk("hold_stall", 64'(bus.stall_o), 64'd1);
            chk("hold_cnt", 64'(bus.stall_cnt_o), 64'd1);
        end
        bus.hold_i = 1'b0;
        tick();
        chk("hold_release_cnt", 64'(bus.stall_cnt_o), 64'd2);
        tick();
        chk("hold_release_rd", 64'(bus.ex_rd_o), 64'd8);

        // five more hazards: 16-bit counter reaches 7, 2-bit counter stops at 3
        for (int i = 0; i < 5; i++) begin
            lw_x7(); tick();
            add_x8_x7_x1(); tick(); tick();
        end
        chk("sat_main_cnt", 64'(bus.stall_cnt_o), 64'd7);
        chk("sat_cnt_3", 64'(sat.stall_cnt_o), 64'd3);

        // empty ID slot: fields captured, control dropped
        set_id(1'b0, 5'd3, 5'd4, 5'd6, 1'b1, 1'b1, 32'h77, 32'h88, 32'h9, 10'h3FF, C_LW); tick();
        chk("inv_ctrl", 64'(bus.ex_ctrl_o), 64'd0);
        chk("inv_valid", 64'(bus.ex_valid_o), 64'd0);
        chk("inv_rd", 64'(bus.ex_rd_o), 64'd6);

        // asynchronous reset mid-stream
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 32'h1234, 32'h55, 32'h0, 10'h000, C_ADD); tick();
        chk("pre_rst_valid", 64'(bus.ex_valid_o), 64'd1);
        #1 rst_i = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.ex_valid_o), 64'd0);
        chk("arst_rd", 64'(bus.ex_rd_o), 64'd0);
        chk("arst_rs1_data", 64'(bus.ex_rs1_data_o), 64'd0);
        chk("arst_ctrl", 64'(bus.ex_ctrl_o), 64'd0);
        chk("arst_cnt", 64'(bus.stall_cnt_o), 64'd0);
        tick();
        rst_i = 1'b1;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
